or_pipe_arbiter: RTL and testbench

- Round-robin arbiter that shares one two-stage registered OR datapath among N requesters.
- Stage 1 registers Z = A | B; stage 2 registers Q = Z.
- Each result leaves tagged with the requester index, under a valid/ready handshake with backpressure.
- Sits between several producers and one downstream consumer of OR results; the datapath is owned and sequenced here, not instantiated separately.

---
 rtl/or_pipe_arbiter.sv | 144 ++++++++++++++
 tb/tb_or_pipe_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/or_pipe_arbiter.sv
// Round-robin arbiter feeding a two-stage registered OR datapath; results leave tagged with the requester index.
// Optional grant lock is compiled in with `define ARB_LOCK_EN.
module or_pipe_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  input  logic [N-1:0]     req_lock,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [IDW-1:0]   out_id,
  input  logic             out_ready
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           lock_q, lock_d;
  logic           s1_valid_q, s1_valid_d;
  logic [W-1:0]   s1_data_q, s1_data_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [IDW-1:0] out_id_q, out_id_d;

  logic           en;
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic           xfer;
  logic [W-1:0]   gnt_a;
  logic [W-1:0]   gnt_b;

  function automatic logic [IDW-1:0] inc_idx(input logic [IDW-1:0] i);
    if (int'(i) == N - 1) return '0;
    return i + IDW'(1);
  endfunction

  // First valid requester scanning upward from p, wrapping modulo N.
  function automatic logic [IDW:0] pick(input logic [N-1:0] v, input logic [IDW-1:0] p);
    logic           found;
    logic [IDW-1:0] idx;
    int             j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      j = (int'(p) + i) % N;
      if (!found && v[j]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    en                   = !(out_valid_q && !out_ready);
    {gnt_found, gnt_idx} = pick(req_valid, ptr_q);
    req_ready            = '0;
    if (en && !rst && gnt_found) req_ready[gnt_idx] = 1'b1;
    xfer  = |(req_valid & req_ready);
    gnt_a = req_a[int'(gnt_idx)*W +: W];
    gnt_b = req_b[int'(gnt_idx)*W +: W];
  end

  // Stage boundary: stage 1 captures the granted A|B, stage 2 takes stage 1.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_id_d     = s1_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (en) begin
      out_valid_d = s1_valid_q;
      out_data_d  = s1_data_q;
      out_id_d    = s1_id_q;
      s1_valid_d  = xfer;
      if (xfer) begin
        s1_data_d = gnt_a | gnt_b;
        s1_id_d   = gnt_idx;
      end
    end
  end

`ifdef ARB_LOCK_EN
  // A locked pointer stays on its owner until it is accepted unlocked or idles while the pipe moves.
  always_comb begin
    ptr_d  = ptr_q;
    lock_d = lock_q;
    if (xfer) begin
      if (req_lock[gnt_idx]) begin
        ptr_d  = gnt_idx;
        lock_d = 1'b1;
      end else begin
        ptr_d  = inc_idx(gnt_idx);
        lock_d = 1'b0;
      end
    end else if (en && lock_q && !req_valid[ptr_q]) begin
      ptr_d  = inc_idx(ptr_q);
      lock_d = 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;

  always_comb begin
    ptr_d  = ptr_q;
    lock_d = 1'b0;
    if (xfer) ptr_d = inc_idx(gnt_idx);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_id_q     <= s1_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_or_pipe_arbiter.sv
// Directed bench for or_pipe_arbiter (N=4, W=8): reset, latency, fairness, backpressure, mid-op reset, grant order.
module tb_or_pipe_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_lock;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [IDW-1:0]   out_id;
  logic             out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  logic [W-1:0] res [N];

  always #5 clk = ~clk;

  or_pipe_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_lock(req_lock), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
  endtask

  task automatic default_ops();
    for (int i = 0; i < N; i++) begin
      opa[i] = W'(i * 8'h11);
      opb[i] = 8'h80;
    end
    res[0] = 8'h80; res[1] = 8'h91; res[2] = 8'hA2; res[3] = 8'hB3;
    load_ops();
  endtask

  int exp_gnt [6];
  int beats1;

  initial begin
    rst = 1'b1; req_valid = 4'b1111; req_lock = '0; out_ready = 1'b1;
    default_ops();

    // reset state with all requesters valid
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_id", 32'(out_id), 32'h0);
    end
    rst = 1'b0; #1;
    chk("first_grant", 32'(req_ready), 32'b0001);

    // single requester latency
    req_valid = 4'b0100; opa[2] = 8'h0F; opb[2] = 8'hA0; load_ops(); #1;
    chk("lat_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    chk("lat_k_valid", 32'(out_valid), 32'h0);
    req_valid = 4'b0000; #1;
    chk("lat_idle_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'h1);
    chk("lat_data", 32'(out_data), 32'hAF);
    chk("lat_id", 32'(out_id), 32'h2);

    // fairness from a fresh pointer
    rst = 1'b1; req_valid = 4'b1111; default_ops();
    @(negedge clk);
    rst = 1'b0; #1;
    for (int c = 0; c < 8; c++) begin
      chk("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        chk("rr_valid", 32'(out_valid), 32'h1);
        chk("rr_id", 32'(out_id), 32'((c - 2) % 4));
        chk("rr_data", 32'(out_data), 32'(res[(c - 2) % 4]));
      end
      @(negedge clk);
    end

    // backpressure: out holds id2, stage 1 holds id3
    out_ready = 1'b0; #1;
    repeat (5) begin
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_id", 32'(out_id), 32'h2);
      chk("bp_data", 32'(out_data), 32'hA2);
      @(negedge clk);
    end
    out_ready = 1'b1; req_valid = 4'b0000; #1;
    chk("bp_rel_ready", 32'(req_ready), 32'h0);
    chk("bp_rel_id", 32'(out_id), 32'h2);
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'h1);
    chk("drain_id", 32'(out_id), 32'h3);
    chk("drain_data", 32'(out_data), 32'hB3);
    @(negedge clk);
    chk("drain_empty", 32'(out_valid), 32'h0);

    // mid-operation reset with two transfers in flight
    req_valid = 4'b0011; #1;
    chk("mr_g0", 32'(req_ready), 32'b0001);
    @(negedge clk);
    chk("mr_g1", 32'(req_ready), 32'b0010);
    @(negedge clk);
    chk("mr_full", 32'(out_valid), 32'h1);
    out_ready = 1'b0; rst = 1'b1; req_valid = 4'b1111; #1;
    chk("mr_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("mr_cleared", 32'(out_valid), 32'h0);
    rst = 1'b0; out_ready = 1'b1; #1;
    chk("mr_ptr0", 32'(req_ready), 32'b0001);
    @(negedge clk);
    chk("mr_no_beat", 32'(out_valid), 32'h0);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("mr_new_valid", 32'(out_valid), 32'h1);
    chk("mr_new_id", 32'(out_id), 32'h0);
    chk("mr_new_data", 32'(out_data), 32'h80);
    @(negedge clk);
    chk("mr_new_empty", 32'(out_valid), 32'h0);

    // grant order with requester 1 sending three beats, lock 1,1,0
`ifdef ARB_LOCK_EN
    exp_gnt = '{0, 1, 1, 1, 3, 0};
`else
    exp_gnt = '{0, 1, 3, 0, 1, 3};
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; beats1 = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = {1'b1, 1'b0, (beats1 < 3), 1'b1};
      req_lock  = (beats1 < 2) ? 4'b0010 : 4'b0000;
      #1;
      chk("order_gnt", 32'(req_ready), 32'(1 << exp_gnt[c]));
      if (exp_gnt[c] == 1) beats1++;
      @(negedge clk);
    end
    req_valid = 4'b0000; req_lock = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
